// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package fetch_pkg;

   localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_item_t;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage

// File: rtl/pc_fifo.sv
// Small PC FIFO, one entry per outstanding fetch; read data is the head entry, combinational.
// Push and pop may share a cycle; the owner guarantees no overflow/underflow, so there is no backpressure.
module pc_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   input  logic         pop_vld,
   output logic [W-1:0] pop_dat
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (push_vld) begin
            r_mem[r_wptr] <= push_dat;
            r_wptr        <= nxt(r_wptr);
         end
         if (pop_vld) r_rptr <= nxt(r_rptr);
      end
   end

   assign pop_dat = r_mem[r_rptr];

endmodule

// File: rtl/fetch_pack.sv
// Fetch front end: issues aligned I-cache requests and packs responses into two queue lanes.
// Response to lanes in 1 cycle; requests are throttled by queue credits and the in-flight cap.
module fetch_pack
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
   parameter int          MAX_INFLIGHT = 2,
   parameter int          QDEPTH       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [31:0] req_addr,
   input  logic        resp_valid,
   input  logic [63:0] resp_data,
   input  logic [3:0]  q_valids,
   output logic        vinA,
   output logic [63:0] inA,
   output logic        vinB,
   output logic [63:0] inB
);
   localparam int CW = $clog2(MAX_INFLIGHT + 1);

   logic [31:0]   r_pc;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_discard;
   logic          r_run;
   logic          r_vinA;
   logic          r_vinB;
   fetch_item_t   r_inA;
   fetch_item_t   r_inB;

   logic          w_acc;
   logic          w_rsp;
   logic [31:0]   w_rq_pc;
   logic [CW-1:0] w_inflight_nxt;
   logic [7:0]    w_free;
   logic [7:0]    w_reserved;

   // Live in-flight requests each reserve two slots; lanes on the output are not yet in q_valids.
   assign w_free     = 8'(QDEPTH) - 8'(popcount4(q_valids));
   assign w_reserved = 8'({r_inflight - r_discard, 1'b0}) + 8'(r_vinA) + 8'(r_vinB);

   assign req_valid = r_run & (r_inflight < CW'(MAX_INFLIGHT))
                    & (w_free >= w_reserved + 8'd2) & ~redirect_valid;
   assign req_addr  = {r_pc[31:3], 3'b000};

   assign w_acc          = req_valid & req_ready;
   assign w_rsp          = resp_valid & (r_inflight != '0);
   assign w_inflight_nxt = r_inflight + CW'(w_acc) - CW'(w_rsp);

   pc_fifo #(.DEPTH(MAX_INFLIGHT), .W(32)) u_rq_pc (
      .clk      (clk),
      .rst      (rst),
      .push_vld (w_acc),
      .push_dat (r_pc),
      .pop_vld  (w_rsp),
      .pop_dat  (w_rq_pc)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pc       <= RESET_PC;
         r_inflight <= '0;
         r_discard  <= '0;
         r_run      <= 1'b0;
         r_vinA     <= 1'b0;
         r_vinB     <= 1'b0;
         r_inA      <= '0;
         r_inB      <= '0;
      end else begin
         r_run      <= 1'b1;
         r_inflight <= w_inflight_nxt;
         r_vinA     <= 1'b0;
         r_vinB     <= 1'b0;
         if (redirect_valid) begin
            // Everything still outstanding after this edge belongs to the old path.
            r_pc      <= redirect_pc;
            r_discard <= w_inflight_nxt;
         end else begin
            if (w_acc) r_pc <= {r_pc[31:3] + 29'd1, 3'b000};
            if (w_rsp) begin
               if (r_discard != '0) begin
                  r_discard <= r_discard - 1'b1;
               end else if (!w_rq_pc[2]) begin
                  r_vinA <= 1'b1;
                  r_inA  <= '{pc: w_rq_pc, instr: resp_data[31:0]};
                  r_vinB <= 1'b1;
                  r_inB  <= '{pc: w_rq_pc + 32'd4, instr: resp_data[63:32]};
               end else begin
                  r_vinA <= 1'b1;
                  r_inA  <= '{pc: w_rq_pc, instr: resp_data[63:32]};
               end
            end
         end
      end
   end

   assign vinA = r_vinA;
   assign inA  = r_inA;
   assign vinB = r_vinB;
   assign inB  = r_inB;

   a_resp_needs_request: assert property (@(posedge clk) disable iff (!rst)
      resp_valid |-> (r_inflight != '0));

endmodule

// File: tb/tb_fetch_pack.sv
// Directed bench for fetch_pack with a queue-based reference model and a simple in-order cache.
module tb_fetch_pack;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [31:0] req_addr;
   logic        resp_valid = 1'b0;
   logic [63:0] resp_data = '0;
   logic [3:0]  q_valids = '0;
   logic        vinA, vinB;
   logic [63:0] inA, inB;

   int n_chk  = 0;
   int n_fail = 0;

   // bench-side cache: answers in order, one cycle after accept unless held
   int          pend = 0;
   bit          hold = 1'b0;
   logic [63:0] cache_data = 64'h2222_2222_1111_1111;

   // reference model
   bit          m_ok = 1'b0;
   bit          m_run = 1'b0;
   logic [31:0] m_pc = 32'hBFC0_0000;
   bit          m_vA = 1'b0, m_vB = 1'b0;
   logic [63:0] m_inA = '0, m_inB = '0;
   logic [31:0] mq_pc[$];
   bit          mq_st[$];

   fetch_pack dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .resp_valid     (resp_valid),
      .resp_data      (resp_data),
      .q_valids       (q_valids),
      .vinA           (vinA),
      .inA            (inA),
      .vinB           (vinB),
      .inB            (inB)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   function automatic bit model_rv();
      int live;
      int free;
      live = 0;
      foreach (mq_st[i]) if (!mq_st[i]) live++;
      free = 4 - $countones(q_valids);
      return m_run && (mq_pc.size() < 2) && !redirect_valid
             && (free >= 2 * live + int'(m_vA) + int'(m_vB) + 2);
   endfunction

   task automatic model_update();
      logic [31:0] p;
      bit          st, acc, rsp;
      logic [63:0] d;
      if (rst !== 1'b1) begin
         m_pc = 32'hBFC0_0000;
         mq_pc.delete();
         mq_st.delete();
         m_vA = 1'b0;
         m_vB = 1'b0;
         m_run = 1'b0;
         m_ok = 1'b1;
         return;
      end
      acc = model_rv() && req_ready;
      rsp = resp_valid && (mq_pc.size() > 0);
      d = resp_data;
      m_vA = 1'b0;
      m_vB = 1'b0;
      if (rsp) begin
         p  = mq_pc.pop_front();
         st = mq_st.pop_front();
         if (!st && !redirect_valid) begin
            if (!p[2]) begin
               m_vA = 1'b1; m_inA = {p, d[31:0]};
               m_vB = 1'b1; m_inB = {p + 32'd4, d[63:32]};
            end else begin
               m_vA = 1'b1; m_inA = {p, d[63:32]};
            end
         end
      end
      if (acc) begin
         mq_pc.push_back(m_pc);
         mq_st.push_back(1'b0);
         m_pc = {m_pc[31:3] + 29'd1, 3'b000};
      end
      if (redirect_valid) begin
         m_pc = redirect_pc;
         foreach (mq_st[i]) mq_st[i] = 1'b1;
      end
      m_run = 1'b1;
   endtask

   // compare process: check outputs mid-cycle, then advance the model across the next edge
   initial begin
      bit exp_rv;
      forever begin
         @(negedge clk);
         if (m_ok) begin
            exp_rv = model_rv();
            chk("req_valid", 64'(req_valid), 64'(exp_rv));
            if (exp_rv) chk("req_addr", 64'(req_addr), 64'({m_pc[31:3], 3'b000}));
            chk("vinA", 64'(vinA), 64'(m_vA));
            chk("vinB", 64'(vinB), 64'(m_vB));
            if (m_vA) chk("inA", inA, m_inA);
            if (m_vB) chk("inB", inB, m_inB);
         end
         model_update();
      end
   end

   task automatic tick();
      bit acc_s, rsp_s, rst_s;
      @(negedge clk);
      acc_s = (req_valid === 1'b1) && (req_ready === 1'b1);
      rsp_s = resp_valid;
      rst_s = rst;
      @(posedge clk);
      #1;
      if (!rst_s) pend = 0;
      else pend = pend + int'(acc_s) - int'(rsp_s);
      resp_valid = rst && !hold && (pend > 0);
      resp_data  = cache_data;
   endtask

   task automatic release_resp();
      hold = 1'b0;
      resp_valid = rst && (pend > 0);
      resp_data  = cache_data;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int found;
      // reset and first fetches
      repeat (3) tick();
      rst = 1'b1;
      req_ready = 1'b1;
      #1;
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_vinA", 64'(vinA), 64'd0);
      chk("rst_vinB", 64'(vinB), 64'd0);
      tick();
      #1;
      chk("first_req_valid", 64'(req_valid), 64'd1);
      chk("first_addr", 64'(req_addr), 64'h0000_0000_BFC0_0000);
      tick();
      #1;
      chk("second_addr", 64'(req_addr), 64'h0000_0000_BFC0_0008);
      tick();
      #1;
      chk("s1_vinA", 64'(vinA), 64'd1);
      chk("s1_inA", inA, 64'hBFC0_0000_1111_1111);
      chk("s1_vinB", 64'(vinB), 64'd1);
      chk("s1_inB", inB, 64'hBFC0_0004_2222_2222);
      chk("s1_credit_block", 64'(req_valid), 64'd0);
      tick();
      #1;
      chk("s1_inA2", inA, 64'hBFC0_0008_1111_1111);
      chk("s1_addr3", 64'(req_addr), 64'h0000_0000_BFC0_0010);
      req_ready = 1'b0;
      repeat (3) tick();

      // redirect to a misaligned PC with an idle pipe
      cache_data = 64'hDEAD_BEEF_CAFE_F00D;
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0004;
      #1;
      chk("redir_req_valid", 64'(req_valid), 64'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("redir_addr", 64'(req_addr), 64'h0000_0000_8000_0000);
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      tick();
      #1;
      chk("mis_vinA", 64'(vinA), 64'd1);
      chk("mis_inA", inA, 64'h8000_0004_DEAD_BEEF);
      chk("mis_vinB", 64'(vinB), 64'd0);
      chk("mis_next_addr", 64'(req_addr), 64'h0000_0000_8000_0008);
      repeat (3) tick();

      // credit limit and in-flight cap with responses withheld
      cache_data = 64'h0BAD_F00D_1234_5678;
      hold = 1'b1;
      q_valids = 4'b0011;
      #1;
      chk("credit_open", 64'(req_valid), 64'd1);
      req_ready = 1'b1;
      tick();
      #1;
      chk("credit_closed", 64'(req_valid), 64'd0);
      q_valids = 4'b0001;
      #1;
      chk("credit_free3", 64'(req_valid), 64'd0);
      q_valids = 4'b0000;
      #1;
      chk("credit_free4", 64'(req_valid), 64'd1);
      tick();
      #1;
      chk("cap_reached", 64'(req_valid), 64'd0);
      repeat (3) tick();
      #1;
      chk("cap_held", 64'(req_valid), 64'd0);
      release_resp();
      repeat (6) tick();

      // two stale requests after a redirect pulse
      req_ready = 1'b0;
      repeat (4) tick();
      cache_data = 64'h4444_4444_3333_3333;
      hold = 1'b1;
      req_ready = 1'b1;
      tick();
      tick();
      req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h9000_0000;
      tick();
      redirect_valid = 1'b0;
      release_resp();
      req_ready = 1'b1;
      found = -1;
      for (int i = 0; i < 8; i++) begin
         tick();
         #1;
         if (vinA === 1'b1) begin
            found = i;
            break;
         end
      end
      chk("stale_first_live", 64'(found), 64'd2);
      chk("stale_live_inA", inA, 64'h9000_0000_3333_3333);
      chk("stale_live_inB", inB, 64'h9000_0004_4444_4444);
      req_ready = 1'b0;
      repeat (5) tick();

      // redirect, response and request in the same cycle
      hold = 1'b1;
      req_ready = 1'b1;
      tick();
      tick();
      release_resp();
      redirect_valid = 1'b1;
      redirect_pc = 32'hA000_0008;
      #1;
      chk("same_cycle_req_valid", 64'(req_valid), 64'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("same_cycle_lane0", 64'(vinA | vinB), 64'd0);
      chk("same_cycle_addr", 64'(req_addr), 64'h0000_0000_A000_0008);
      tick();
      #1;
      chk("same_cycle_lane1", 64'(vinA | vinB), 64'd0);
      tick();
      #1;
      chk("same_cycle_live", inA, 64'hA000_0008_3333_3333);

      // reset in the middle of traffic, then mixed queue occupancy
      rst = 1'b0;
      tick();
      #1;
      chk("midrst_vinA", 64'(vinA), 64'd0);
      chk("midrst_req_valid", 64'(req_valid), 64'd0);
      rst = 1'b1;
      tick();
      #1;
      chk("midrst_addr", 64'(req_addr), 64'h0000_0000_BFC0_0000);
      cache_data = 64'h7777_7777_6666_6666;
      q_valids = 4'b0110;
      repeat (4) tick();
      q_valids = 4'b0111;
      repeat (4) tick();
      q_valids = 4'b1000;
      repeat (6) tick();
      req_ready = 1'b0;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
